// File: rtl/alu_wb_ctrl.sv
// ALU writeback / hazard controller: decodes issue, tracks pending multiplies, owns the register-file write port and branch flush.
// Define WB_BYPASS_EN to forward the next writeback and drop the one-cycle RAW bubble on single-cycle results.
module alu_wb_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        issue_valid_i,
    input  logic [15:0] issue_instr_i,
    input  logic [15:0] alu_out_i,
    input  logic [1:0]  alu_status_i,
    input  logic [15:0] ex_instr_i,
    input  logic        br_taken_i,
    input  logic [15:0] br_target_i,
    output logic        stall_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [15:0] redirect_pc_o,
    output logic        wb_en_o,
    output logic [3:0]  wb_addr_o,
    output logic [15:0] wb_data_o,
    output logic        fwd_valid_o,
    output logic [3:0]  fwd_addr_o,
    output logic [15:0] fwd_data_o
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_FLUSH1 = 2'd1,
        S_FLUSH2 = 2'd2
    } state_t;

    state_t      state_q;
    logic        flush_q;
    logic        redirect_valid_q;
    logic [15:0] redirect_pc_q;
    logic        wb_en_q;
    logic [3:0]  wb_addr_q;
    logic [15:0] wb_data_q;
    logic        wb_single_q;
    logic [3:0]  fifo_rd_q [3];
    logic [1:0]  fifo_cnt_q;

    logic        wb_en_d;
    logic [3:0]  wb_addr_d;
    logic [15:0] wb_data_d;
    logic        wb_single_d;
    logic [3:0]  fifo_rd_d [3];
    logic [1:0]  fifo_cnt_d;

    logic [3:0]  op;
    logic        has_rd;
    logic [3:0]  rd;
    logic        src_a_v;
    logic [3:0]  src_a;
    logic        src_b_v;
    logic [3:0]  src_b;
    logic [3:0]  ex_rd;

    logic        mul_ret;
    logic        pop;
    logic        push;
    logic        alu_busy;
    logic        fifo_full;
    logic        raw_fifo;
    logic        raw_wb;
    logic        stall;
    logic        accept;
    logic        iss_wb;

    assign op    = issue_instr_i[15:12];
    assign ex_rd = ex_instr_i[11:8];

    always_comb begin
        has_rd  = 1'b0;
        rd      = issue_instr_i[11:8];
        src_a_v = 1'b0;
        src_a   = issue_instr_i[7:4];
        src_b_v = 1'b0;
        src_b   = issue_instr_i[3:0];
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                has_rd  = 1'b1;
                src_a_v = 1'b1;
                src_b_v = 1'b1;
            end
            4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
                has_rd  = 1'b1;
                src_b_v = 1'b1;
            end
            4'hD: begin
                src_a   = issue_instr_i[11:8];
                src_a_v = 1'b1;
                src_b_v = 1'b1;
            end
            4'hE: begin
                has_rd = 1'b1;
                rd     = issue_instr_i[3:0];
            end
            4'hF: begin
                has_rd  = 1'b1;
                rd      = issue_instr_i[3:0];
                src_a   = issue_instr_i[11:8];
                src_a_v = 1'b1;
            end
            default: ;
        endcase
    end

    // Hazard detection against pending multiplies and, without bypass, the write in flight
    always_comb begin
        raw_fifo = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < fifo_cnt_q) begin
                if ((src_a_v && (src_a == fifo_rd_q[i])) ||
                    (src_b_v && (src_b == fifo_rd_q[i]))) begin
                    raw_fifo = 1'b1;
                end
            end
        end
`ifdef WB_BYPASS_EN
        raw_wb = 1'b0;
`else
        raw_wb = wb_en_q && wb_single_q &&
                 ((src_a_v && (src_a == wb_addr_q)) || (src_b_v && (src_b == wb_addr_q)));
`endif
    end

    assign mul_ret   = (alu_status_i != 2'd0);
    assign alu_busy  = mul_ret && (op != 4'h5);
    assign fifo_full = (op == 4'h5) && (fifo_cnt_q == 2'd3) && !mul_ret;
    assign stall     = (state_q == S_RUN) && issue_valid_i &&
                       (alu_busy || raw_fifo || raw_wb || fifo_full);
    assign accept    = issue_valid_i && !stall && (state_q == S_RUN);
    assign pop       = mul_ret && (fifo_cnt_q != 2'd0);
    assign push      = accept && (op == 4'h5);
    assign iss_wb    = accept && has_rd && (op != 4'h5) && !mul_ret;

    // In-order pending-multiply queue; a pop shifts toward the head before any push lands
    always_comb begin
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q;
        if (pop) begin
            fifo_rd_d[0] = fifo_rd_q[1];
            fifo_rd_d[1] = fifo_rd_q[2];
            fifo_cnt_d   = fifo_cnt_q - 2'd1;
        end
        if (push) begin
            for (int i = 0; i < 3; i++) begin
                if (2'(i) == fifo_cnt_d) begin
                    fifo_rd_d[i] = rd;
                end
            end
            fifo_cnt_d = fifo_cnt_d + 2'd1;
        end
    end

    always_comb begin
        wb_en_d     = 1'b0;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        wb_single_d = 1'b0;
        if (pop) begin
            wb_en_d = (ex_rd != 4'd0);
            if (wb_en_d) begin
                wb_addr_d = ex_rd;
                wb_data_d = alu_out_i;
            end
        end else if (iss_wb) begin
            wb_en_d     = (rd != 4'd0);
            wb_single_d = wb_en_d;
            if (wb_en_d) begin
                wb_addr_d = rd;
                wb_data_d = alu_out_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= S_RUN;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 16'd0;
            wb_en_q          <= 1'b0;
            wb_addr_q        <= 4'd0;
            wb_data_q        <= 16'd0;
            wb_single_q      <= 1'b0;
            fifo_cnt_q       <= 2'd0;
            fifo_rd_q        <= '{default: 4'd0};
        end else begin
            wb_en_q          <= wb_en_d;
            wb_addr_q        <= wb_addr_d;
            wb_data_q        <= wb_data_d;
            wb_single_q      <= wb_single_d;
            fifo_cnt_q       <= fifo_cnt_d;
            fifo_rd_q        <= fifo_rd_d;
            redirect_valid_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (accept && br_taken_i) begin
                        state_q          <= S_FLUSH1;
                        flush_q          <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= br_target_i;
                    end
                end
                S_FLUSH1: begin
                    state_q <= S_FLUSH2;
                    flush_q <= 1'b1;
                end
                S_FLUSH2: begin
                    state_q <= S_RUN;
                    flush_q <= 1'b0;
                end
                default: begin
                    state_q <= S_RUN;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign stall_o          = stall;
    assign flush_o          = flush_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign wb_en_o          = wb_en_q;
    assign wb_addr_o        = wb_addr_q;
    assign wb_data_o        = wb_data_q;

`ifdef WB_BYPASS_EN
    assign fwd_valid_o = wb_en_d && !rst_i;
    assign fwd_addr_o  = rst_i ? 4'd0 : wb_addr_d;
    assign fwd_data_o  = rst_i ? 16'd0 : wb_data_d;

    logic unused_bits;
    assign unused_bits = ^{ex_instr_i[15:12], ex_instr_i[7:0], wb_single_q};
`else
    assign fwd_valid_o = 1'b0;
    assign fwd_addr_o  = 4'd0;
    assign fwd_data_o  = 16'd0;

    logic unused_bits;
    assign unused_bits = ^{ex_instr_i[15:12], ex_instr_i[7:0]};
`endif

endmodule

// File: tb/tb_alu_wb_ctrl.sv
// Scoreboard bench for alu_wb_ctrl: directed issue sequences push expected writebacks, a monitor pops on every wb_en.
module tb_alu_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [15:0] issue_instr;
    logic [15:0] alu_out;
    logic [1:0]  alu_status;
    logic [15:0] ex_instr;
    logic        br_taken;
    logic [15:0] br_target;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        fwd_valid;
    logic [3:0]  fwd_addr;
    logic [15:0] fwd_data;

    alu_wb_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .issue_valid_i    (issue_valid),
        .issue_instr_i    (issue_instr),
        .alu_out_i        (alu_out),
        .alu_status_i     (alu_status),
        .ex_instr_i       (ex_instr),
        .br_taken_i       (br_taken),
        .br_target_i      (br_target),
        .stall_o          (stall),
        .flush_o          (flush),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .wb_en_o          (wb_en),
        .wb_addr_o        (wb_addr),
        .wb_data_o        (wb_data),
        .fwd_valid_o      (fwd_valid),
        .fwd_addr_o       (fwd_addr),
        .fwd_data_o       (fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } wb_t;

    wb_t exp_q[$];
    wb_t mon_e;
    int  checks = 0;
    int  errors = 0;

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input logic [3:0] addr, input logic [15:0] data);
        exp_q.push_back('{addr: addr, data: data});
    endtask

    task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] aout,
                         input logic [1:0] st, input logic [15:0] exi,
                         input logic bt, input logic [15:0] btg);
        @(negedge clk);
        issue_valid = v;
        issue_instr = instr;
        alu_out     = aout;
        alu_status  = st;
        ex_instr    = exi;
        br_taken    = bt;
        br_target   = btg;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 16'h0, 2'd0, 16'h0, 1'b0, 16'h0);
    endtask

    // Monitor: every writeback must match the oldest outstanding expectation
    always @(posedge clk) begin
        #1;
        if (wb_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got addr %0d data 0x%0h, required no writeback",
                         wb_addr, wb_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_addr", 32'(wb_addr), 32'(mon_e.addr));
                check("wb_data", 32'(wb_data), 32'(mon_e.data));
            end
        end
    end

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; issue_instr = 16'h0; alu_out = 16'h0; alu_status = 2'd0;
        ex_instr = 16'h0; br_taken = 1'b0; br_target = 16'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_wb_en", 32'(wb_en), 0);
        check("rst_wb_addr", 32'(wb_addr), 0);
        check("rst_wb_data", 32'(wb_data), 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_redirect_valid", 32'(redirect_valid), 0);
        check("rst_redirect_pc", 32'(redirect_pc), 0);
        check("rst_fwd_valid", 32'(fwd_valid), 0);
        rst = 1'b0;

        // single-cycle add, then a dependent add
        drive(1'b1, ins(4'h0, 4'd3, 4'd1, 4'd2), 16'h0012, 2'd0, 16'h0, 1'b0, 16'h0);
        check("add_stall", 32'(stall), 0);
        expect_wb(4'd3, 16'h0012);
        drive(1'b1, ins(4'h1, 4'd4, 4'd3, 4'd2), 16'h0034, 2'd0, 16'h0, 1'b0, 16'h0);
`ifdef WB_BYPASS_EN
        check("dep_add_no_bubble", 32'(stall), 0);
`else
        check("dep_add_bubble", 32'(stall), 1);
        drive(1'b1, ins(4'h1, 4'd4, 4'd3, 4'd2), 16'h0034, 2'd0, 16'h0, 1'b0, 16'h0);
        check("dep_add_after_bubble", 32'(stall), 0);
`endif
        expect_wb(4'd4, 16'h0034);

        // multiply rd=5 then a consumer of r5
        drive(1'b1, ins(4'h5, 4'd5, 4'd1, 4'd2), 16'h0000, 2'd0, 16'h0, 1'b0, 16'h0);
        check("mul5_stall", 32'(stall), 0);
        drive(1'b1, ins(4'h0, 4'd6, 4'd5, 4'd1), 16'h0000, 2'd0, 16'h0, 1'b0, 16'h0);
        check("raw_mul_stall1", 32'(stall), 1);
        drive(1'b1, ins(4'h0, 4'd6, 4'd5, 4'd1), 16'h0000, 2'd0, 16'h0, 1'b0, 16'h0);
        check("raw_mul_stall2", 32'(stall), 1);
        drive(1'b1, ins(4'h0, 4'd6, 4'd5, 4'd1), 16'h0099, 2'd1, ins(4'h5, 4'd5, 4'd1, 4'd2), 1'b0, 16'h0);
        check("mul_return_stall", 32'(stall), 1);
        expect_wb(4'd5, 16'h0099);
        drive(1'b1, ins(4'h0, 4'd6, 4'd5, 4'd1), 16'h0077, 2'd0, 16'h0, 1'b0, 16'h0);
        check("raw_resolved", 32'(stall), 0);
        expect_wb(4'd6, 16'h0077);

        // fill the multiply queue
        for (int i = 7; i <= 9; i++) begin
            drive(1'b1, ins(4'h5, 4'(i), 4'd1, 4'd2), 16'h0, 2'd0, 16'h0, 1'b0, 16'h0);
            check("mul_fill_stall", 32'(stall), 0);
        end
        drive(1'b1, ins(4'h5, 4'd10, 4'd1, 4'd2), 16'h0, 2'd0, 16'h0, 1'b0, 16'h0);
        check("mul_full_stall", 32'(stall), 1);
        drive(1'b1, ins(4'h5, 4'd10, 4'd1, 4'd2), 16'h0700, 2'd2, ins(4'h5, 4'd7, 4'd1, 4'd2), 1'b0, 16'h0);
        check("mul_full_pushpop", 32'(stall), 0);
        expect_wb(4'd7, 16'h0700);
        drive(1'b1, ins(4'h5, 4'd11, 4'd1, 4'd2), 16'h0, 2'd0, 16'h0, 1'b0, 16'h0);
        check("mul_count_still_3", 32'(stall), 1);
        for (int i = 8; i <= 10; i++) begin
            drive(1'b0, 16'h0, 16'(i * 256), 2'd1, ins(4'h5, 4'(i), 4'd1, 4'd2), 1'b0, 16'h0);
            expect_wb(4'(i), 16'(i * 256));
        end
        drive(1'b0, 16'h0, 16'hBAD0, 2'd1, ins(4'h5, 4'd12, 4'd1, 4'd2), 1'b0, 16'h0);
        idle();

        // taken branch with link, multiply returning during flush
        drive(1'b1, ins(4'h5, 4'd11, 4'd1, 4'd2), 16'h0, 2'd0, 16'h0, 1'b0, 16'h0);
        check("mul11_stall", 32'(stall), 0);
        drive(1'b1, ins(4'hE, 4'd0, 4'd0, 4'd2), 16'h0011, 2'd0, 16'h0, 1'b1, 16'h0040);
        check("br_stall", 32'(stall), 0);
        expect_wb(4'd2, 16'h0011);
        @(posedge clk); #1;
        check("br_redirect_valid", 32'(redirect_valid), 1);
        check("br_redirect_pc", 32'(redirect_pc), 32'h0040);
        check("br_flush1", 32'(flush), 1);
        drive(1'b1, ins(4'h0, 4'd13, 4'd1, 4'd2), 16'h0B0B, 2'd1, ins(4'h5, 4'd11, 4'd1, 4'd2), 1'b1, 16'h0099);
        expect_wb(4'd11, 16'h0B0B);
        @(posedge clk); #1;
        check("br_flush2", 32'(flush), 1);
        check("br_redirect_once", 32'(redirect_valid), 0);
        drive(1'b1, ins(4'h0, 4'd13, 4'd1, 4'd2), 16'h1313, 2'd0, 16'h0, 1'b1, 16'h0099);
        @(posedge clk); #1;
        check("br_flush_done", 32'(flush), 0);
        check("br_redirect_pc_hold", 32'(redirect_pc), 32'h0040);
        idle();
        idle();

        // reset in FLUSH1 with two multiplies pending
        drive(1'b1, ins(4'h5, 4'd12, 4'd1, 4'd2), 16'h0, 2'd0, 16'h0, 1'b0, 16'h0);
        drive(1'b1, ins(4'h5, 4'd13, 4'd1, 4'd2), 16'h0, 2'd0, 16'h0, 1'b0, 16'h0);
        check("mul13_stall", 32'(stall), 0);
        drive(1'b1, ins(4'hB, 4'd0, 4'd0, 4'd0), 16'h0, 2'd0, 16'h0, 1'b1, 16'h0080);
        @(posedge clk); #1;
        check("br2_redirect_pc", 32'(redirect_pc), 32'h0080);
        check("br2_flush1", 32'(flush), 1);
        @(negedge clk);
        rst = 1'b1;
        issue_valid = 1'b0; alu_status = 2'd1; ex_instr = ins(4'h5, 4'd12, 4'd1, 4'd2);
        alu_out = 16'hDEAD; br_taken = 1'b0;
        @(posedge clk); #1;
        check("midrst_flush", 32'(flush), 0);
        check("midrst_redirect_valid", 32'(redirect_valid), 0);
        check("midrst_redirect_pc", 32'(redirect_pc), 0);
        check("midrst_wb_en", 32'(wb_en), 0);
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'hBEEF, 2'd1, ins(4'h5, 4'd12, 4'd1, 4'd2), 1'b0, 16'h0);
        drive(1'b1, ins(4'h0, 4'd14, 4'd1, 4'd2), 16'h00EE, 2'd0, 16'h0, 1'b0, 16'h0);
        check("post_rst_run_stall", 32'(stall), 0);
        expect_wb(4'd14, 16'h00EE);

        // rd=0 suppression, then a reader of r0
        drive(1'b1, ins(4'h0, 4'd0, 4'd1, 4'd2), 16'h1234, 2'd0, 16'h0, 1'b0, 16'h0);
        check("rd0_stall", 32'(stall), 0);
        drive(1'b1, ins(4'h0, 4'd1, 4'd0, 4'd2), 16'h0055, 2'd0, 16'h0, 1'b0, 16'h0);
        check("rd0_dep_stall", 32'(stall), 0);
`ifdef WB_BYPASS_EN
        check("rd0_dep_fwd_valid", 32'(fwd_valid), 1);
        check("rd0_dep_fwd_addr", 32'(fwd_addr), 1);
`else
        check("rd0_dep_fwd_valid", 32'(fwd_valid), 0);
`endif
        expect_wb(4'd1, 16'h0055);

        repeat (4) idle();
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_wb_ctrl.md
ALU_WB_CTRL -- requirements
Module: alu_wb_ctrl

Interface
REQ-001 clk  input  1  single clock, all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 issue_valid  input  1  issue_instr is presented to the ALU this cycle.
REQ-004 issue_instr  input  16  instruction presented to the ALU; opcode [15:12].
REQ-005 alu_out  input  16  ALU result this cycle.
REQ-006 alu_status  input  2  non-zero means a multiply result is on alu_out this cycle.
REQ-007 ex_instr  input  16  instruction owning a returning multiply result.
REQ-008 br_taken / br_target  input  1 / 16  ALU branch decision and target.
REQ-009 stall  output  1  combinational; hold issue_instr, do not advance.
REQ-010 flush  output  1  registered; discard the younger instruction this cycle.
REQ-011 redirect_valid / redirect_pc  output  1 / 16  registered PC redirect.
REQ-012 wb_en / wb_addr / wb_data  output  1 / 4 / 16  registered register-file write.
REQ-013 fwd_valid / fwd_addr / fwd_data  output  1 / 4 / 16  combinational forward of the next writeback.

Function
REQ-014 Destination decode: ops 0-4, 6-A and 5 write rd=[11:8]; ops E, F write rd=[3:0]; ops B, C, D write nothing.
REQ-015 Source decode: ops 0-5 read [7:4] and [3:0]; ops 6-A read [3:0]; op D reads [11:8] and [3:0]; op F reads [11:8].
REQ-016 Accepted instruction = issue_valid && !stall && state==RUN.
REQ-017 Accepted non-multiply op with a destination and alu_status==0: next cycle wb_en=1, wb_addr=rd, wb_data=alu_out.
REQ-018 Accepted op 5: push {rd} into a 3-entry in-order pending-multiply FIFO; no writeback at issue.
REQ-019 alu_status!=0: next cycle wb_en=1, wb_addr=ex_instr[11:8], wb_data=alu_out; pop the FIFO head.
REQ-020 alu_status!=0 while issue_valid and issue op is not 5: stall=1 (the ALU is occupied by the multiply result).
REQ-021 RAW hazard: stall=1 while any decoded source equals a valid FIFO rd.
REQ-022 Structural: stall=1 on op 5 issue while the FIFO holds 3 entries and alu_status==0; simultaneous push and pop keeps the count unchanged.
REQ-023 rd==0: writeback suppressed (wb_en=0); the FIFO push still occurs for op 5 to keep ordering.
REQ-024 FSM states RUN, FLUSH1, FLUSH2; RUN->FLUSH1 on an accepted br_taken; FLUSH1->FLUSH2->RUN unconditionally.
REQ-025 On the taken-branch cycle: next cycle redirect_valid=1 for one cycle, redirect_pc=br_target.
REQ-026 The branching instruction is not squashed: op E/F link writeback (alu_out) still occurs.
REQ-027 In FLUSH1/FLUSH2: flush=1; issue_valid is ignored (no writeback, no FIFO push, no branch accepted).
REQ-028 Multiply results returning during FLUSH are still written back (the multiply is older than the branch).
REQ-029 A pop with an empty FIFO is ignored, with no writeback.

Reset
REQ-030 rst: state=RUN, FIFO emptied, wb_en=0, wb_addr=0, wb_data=0, flush=0, redirect_valid=0, redirect_pc=0.
REQ-031 rst mid-FLUSH or with multiplies pending: all of the above apply on the next edge; returning results are not written until after rst deasserts.

Configuration
REQ-032 Macro WB_BYPASS_EN defined: fwd_valid/fwd_addr/fwd_data equal the values wb_en/wb_addr/wb_data will take next edge; the RAW check excludes the single-cycle writeback.
REQ-033 WB_BYPASS_EN undefined: fwd_* are driven 0; stall=1 also when a source matches an in-flight single-cycle writeback rd (one-cycle bubble).

Verification
REQ-034 Issue add rd=3 with alu_out=0x0012 -> next cycle wb_en=1, wb_addr=3, wb_data=0x0012.
REQ-035 Issue mul rd=5, then add reading r5 -> stall=1 until alu_status!=0; r5 written with the product; the add is then accepted.
REQ-036 Issue 4 back-to-back multiplies with no result returned -> the 4th stalls; alu_status!=0 the same cycle -> no stall, count stays 3.
REQ-037 Issue op E with pc-derived alu_out=0x0011, br_target=0x0040, br_taken=1 -> wb to rd=[3:0], redirect_valid=1 with pc 0x0040, flush=1 for 2 cycles, and no writeback from the squashed instructions.
REQ-038 Assert rst in FLUSH1 with 2 multiplies pending -> next cycle all outputs 0, state RUN, and a later alu_status!=0 produces no writeback.
REQ-039 Issue op 0 with rd=0 -> wb_en stays 0; with WB_BYPASS_EN, a back-to-back dependent add sees fwd_valid=1 and no stall.
